inst_cache: RTL and testbench

//  Direct-mapped instruction cache between the CPU fetch port (rom_ce/rom_addr/rom_data) and a

---
 rtl/inst_cache.sv | 128 ++++++++++++
 tb/tb_inst_cache.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// -----------------------------------------------------------------------------
// inst_cache
//   Direct-mapped instruction cache between the CPU fetch port and a
//   multi-cycle instruction memory with a req/ack handshake. A hit returns the
//   word in the same cycle. A miss raises stallreq_o and refills the whole
//   4-word line, words 0..3 in order, then commits tag and valid.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   rom_ce_i    fetch enable from pc_reg
//   rom_addr_i  fetch byte address (pc); bits [1:0] ignored
//   rom_data_o  instruction word to if_id (0 unless hit)
//   stallreq_o  fetch stall request to ctrl
//   flush_i     one-cycle pulse: invalidate the entire cache
//   mem_req_o   word read request to instruction memory
//   mem_addr_o  word-aligned request address (0 when idle)
//   mem_data_i  returned word, valid with mem_ack_i
//   mem_ack_i   one pulse per accepted word (ignored while mem_req_o=0)
// -----------------------------------------------------------------------------
module inst_cache #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         r_cnt;
  logic               r_kill;
  logic [TAG_W-1:0]   r_fill_tag;
  logic [INDEX_W-1:0] r_fill_index;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES][4];

  logic [1:0]         w_offset;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_miss;
  logic               w_ack;
  logic               w_unused_lsb;

  assign w_offset     = rom_addr_i[3:2];
  assign w_index      = rom_addr_i[INDEX_W+3:4];
  assign w_tag        = rom_addr_i[31:INDEX_W+4];
  assign w_unused_lsb = ^rom_addr_i[1:0];

  assign w_hit  = rom_ce_i & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_miss = rom_ce_i & ~w_hit;

  assign rom_data_o = w_hit ? r_data[w_index][w_offset] : '0;
  // Gated by rst so the stall request reads 0 while reset is held.
  assign stallreq_o = rst & w_miss;

  // Request and address are pure decodes of registered state, so an
  // asynchronous reset drops mem_req_o immediately.
  assign mem_req_o  = (r_state == S_REFILL);
  assign mem_addr_o = mem_req_o ? {r_fill_tag, r_fill_index, r_cnt, 2'b00} : '0;
  assign w_ack      = mem_req_o & mem_ack_i;

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_kill       <= 1'b0;
      r_fill_tag   <= '0;
      r_fill_index <= '0;
      r_valid      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_fill_tag   <= w_tag;
            r_fill_index <= w_index;
            r_cnt        <= 2'd0;
            r_kill       <= 1'b0;
            // The victim line is overwritten word by word during the refill,
            // so it must stop hitting before the first word lands.
            r_valid[w_index] <= 1'b0;
            r_state      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (flush_i) r_kill <= 1'b1;
          if (w_ack) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          if (!r_kill && !flush_i) r_valid[r_fill_index] <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Placed last so a flush overrides any valid update in the same cycle.
      if (flush_i) r_valid <= '0;
    end
  end

  // NOTE: tag and data arrays carry no reset; a line is only observable once
  // its valid bit is set, so clearing valid alone is sufficient.
  always_ff @(posedge clk) begin
    if (w_ack) r_data[r_fill_index][r_cnt] <= mem_data_i;
    if (r_state == S_COMMIT) r_tag[r_fill_index] <= r_fill_tag;
  end

endmodule

// File: tb/tb_inst_cache.sv
module tb_inst_cache;

  localparam int INDEX_W = 6;
  localparam int MAXC    = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = '0;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        flush_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_ack_i = 1'b0;

  inst_cache #(.INDEX_W(INDEX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stallreq_o (stallreq_o),
    .flush_i    (flush_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          ack_delay = 0;
  bit          noise_en = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] held_addr = '0;
  logic [31:0] req_log[$];

  // Instruction memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory responder: acks ack_delay cycles after the request appears, logs
  // every acked address and checks the address holds steady while waiting.
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (wait_cnt == 0) held_addr = mem_addr_o;
      else check("addr_stable", mem_addr_o, held_addr);
      if (wait_cnt >= ack_delay) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(mem_addr_o);
        req_log.push_back(mem_addr_o);
        wait_cnt   = 0;
      end else begin
        mem_ack_i  = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt   = 0;
      mem_ack_i  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_data_i = noise_en ? $urandom : '0;
    end
  end

  task automatic drive_fetch(input logic [31:0] a, input int d);
    @(negedge clk);
    rom_addr_i = a;
    rom_ce_i   = 1'b1;
    ack_delay  = d;
    req_log.delete();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    #1;
    while (stallreq_o && n < MAXC) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_bounded", 32'(n < MAXC), 32'd1);
  endtask

  task automatic check_log(input string name, input logic [31:0] a, input int first, input int cnt);
    for (int i = 0; i < cnt; i++)
      check($sformatf("%s_req%0d", name, i),
            (first + i < req_log.size()) ? req_log[first + i] : 32'hDEAD_DEAD,
            (a & 32'hFFFF_FFF0) + 32'(4 * i));
  endtask

  task automatic fetch_and_check(input string name, input logic [31:0] a, input int d,
                                 input int exp_stall);
    int n;
    drive_fetch(a, d);
    wait_done(n);
    check({name, "_stall"}, n, exp_stall);
    check({name, "_data"}, rom_data_o, mem_word(a));
    check({name, "_nreq"}, req_log.size(), (exp_stall == 0) ? 0 : 4);
    if (exp_stall != 0) check_log(name, a, 0, 4);
  endtask

  task automatic idle_ce0(input string name, input logic [31:0] a);
    @(negedge clk);
    rom_ce_i   = 1'b0;
    rom_addr_i = a;
    req_log.delete();
    #1;
    check({name, "_stall"}, stallreq_o, 0);
    check({name, "_data"}, rom_data_o, 0);
    repeat (3) @(negedge clk);
    check({name, "_nreq"}, req_log.size(), 0);
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    rom_ce_i = 1'b0;
    flush_i  = 1'b1;
    @(negedge clk);
    flush_i  = 1'b0;
  endtask

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    int          delay;
    int          exp_stall;
  } vec_t;

  vec_t vecs [16];

  bit          m_valid [64];
  logic [21:0] m_tag   [64];

  initial begin
    int n;
    vecs = '{
      '{1'b0, 32'h0000_0100, 0,  0},   // disabled fetch: no refill
      '{1'b1, 32'h0000_0100, 0,  6},   // cold miss, same-cycle ack
      '{1'b1, 32'h0000_0104, 0,  0},   // hits in the filled line
      '{1'b1, 32'h0000_0108, 0,  0},
      '{1'b1, 32'h0000_010C, 0,  0},
      '{1'b0, 32'h0000_0104, 0,  0},   // valid line but ce=0: data 0
      '{1'b1, 32'h0000_0000, 0,  6},   // index 0
      '{1'b1, 32'h0000_0400, 0,  6},   // conflict on index 0
      '{1'b1, 32'h0000_0000, 0,  6},   // evicted: misses again
      '{1'b1, 32'h0000_03F0, 0,  6},   // index 63
      '{1'b1, 32'h0000_03F6, 0,  0},   // byte bits ignored
      '{1'b1, 32'h0000_07F0, 0,  6},   // conflict on index 63
      '{1'b1, 32'h0000_03F0, 0,  6},
      '{1'b1, 32'h0000_0280, 3, 18},   // delayed ack: 4 x 4 + 2
      '{1'b1, 32'h0000_028F, 0,  0},
      '{1'b1, 32'h0000_0102, 0,  0}    // untouched line still hits
    };

    // Reset state, with a fetch already requested.
    rom_ce_i   = 1'b1;
    rom_addr_i = 32'h0000_0100;
    #12;
    check("rst_stall", stallreq_o, 0);
    check("rst_data", rom_data_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    @(negedge clk);
    rom_ce_i = 1'b0;
    rst      = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].ce) fetch_and_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].delay,
                                      vecs[i].exp_stall);
      else idle_ce0($sformatf("vec%0d", i), vecs[i].addr);
    end

    // Flush during a refill: the refill completes but is discarded, and a
    // second refill of the same line follows.
    drive_fetch(32'h0000_0200, 1);
    repeat (3) @(negedge clk);
    check("flush_in_refill", mem_req_o, 1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    wait_done(n);
    check("flush_stall", n, 16);
    check("flush_nreq", req_log.size(), 8);
    check_log("flush_a", 32'h0000_0200, 0, 4);
    check_log("flush_b", 32'h0000_0200, 4, 4);
    check("flush_data", rom_data_o, mem_word(32'h0000_0200));
    fetch_and_check("post_flush_280", 32'h0000_0284, 0, 6);
    fetch_and_check("post_flush_100", 32'h0000_0108, 0, 6);

    // Fetch address moves mid-refill: the refill is not retargeted.
    drive_fetch(32'h0000_0600, 0);
    repeat (2) @(negedge clk);
    rom_addr_i = 32'h0000_0704;
    wait_done(n);
    check("stale_nreq", req_log.size(), 8);
    check_log("stale_a", 32'h0000_0600, 0, 4);
    check_log("stale_b", 32'h0000_0700, 4, 4);
    check("stale_data", rom_data_o, mem_word(32'h0000_0704));
    fetch_and_check("stale_600", 32'h0000_060C, 0, 0);

    // Reset during word 2 of a refill.
    flush_pulse();
    drive_fetch(32'h0000_0100, 0);
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h0000_0108) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_word2", mem_addr_o, 32'h0000_0108);
    rst = 1'b0;
    #1;
    check("rst_mid_req", mem_req_o, 0);
    check("rst_mid_addr", mem_addr_o, 0);
    check("rst_mid_stall", stallreq_o, 0);
    @(negedge clk);
    @(negedge clk);
    req_log.delete();
    rst = 1'b1;
    wait_done(n);
    check("rst_refill_stall", n, 6);
    check("rst_refill_nreq", req_log.size(), 4);
    check_log("rst_refill", 32'h0000_0100, 0, 4);
    check("rst_refill_data", rom_data_o, mem_word(32'h0000_0100));

    // Randomized fetches against a line-level reference model.
    flush_pulse();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    noise_en = 1'b1;
    for (int it = 0; it < 150; it++) begin
      logic [21:0] tg;
      logic [5:0]  ix;
      logic [31:0] a;
      int          d;
      bit          hit;
      if ($urandom_range(0, 9) == 0) begin
        flush_pulse();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) idle_ce0($sformatf("rnd%0d_ce0", it), $urandom);
      case ($urandom_range(0, 3))
        0:       ix = 6'd0;
        1:       ix = 6'd63;
        2:       ix = 6'd1;
        default: ix = 6'($urandom_range(0, 63));
      endcase
      tg  = 22'($urandom_range(0, 2));
      a   = {tg, ix, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d   = $urandom_range(0, 2);
      hit = m_valid[ix] && (m_tag[ix] == tg);
      fetch_and_check($sformatf("rnd%0d", it), a, d, hit ? 0 : 2 + 4 * (d + 1));
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tg;
    end
    noise_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
